// File: rtl/shape_processor_sequencer.sv
// shape_processor_sequencer
//
// Shares the shape processor's control SFR port among NUM_REQ requesters.
// A round-robin arbiter picks one pending request, which is written to the
// processor. The processor's error flag is sampled one cycle after the write.
// On success the SFR is read back. The outcome is then returned as a single
// response tagged with the requester ID. This block is the only master of
// the processor's write and read strobes.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   req_valid      per-requester request pending
//   req_data       per-requester 32-bit SFR write value, slice i = [32*i +: 32]
//   req_ready      one-hot accept pulse, combinational, only in IDLE
//   rsp_valid      response valid, held until rsp_ready
//   rsp_ready      response consumer ready
//   rsp_id         requester that owns the response
//   rsp_data       SFR readback value, 0 when the processor flagged an error
//   rsp_error      processor rejected the write
//   sp_write       one-cycle write strobe to the processor
//   sp_write_data  write data, meaningful while sp_write=1
//   sp_read        one-cycle read strobe to the processor
//   sp_read_data   processor read data, valid while sp_read=1
//   sp_error       processor error flag, valid the cycle after sp_write
//   busy           sequencer is handling a request (state != IDLE)

module shape_processor_sequencer #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_error,
    output logic                  sp_write,
    output logic [31:0]           sp_write_data,
    output logic                  sp_read,
    input  logic [31:0]           sp_read_data,
    input  logic                  sp_error,
    output logic                  busy
);

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        CHECK,
        READ,
        RESP
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     ptr;

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   grant_data;
    logic [ID_W-1:0]     next_ptr;
    logic [ID_W:0]       cand_sum;
    logic [ID_W-1:0]     cand;

    // Round-robin search: candidates are visited in the order ptr, ptr+1, ...
    // wrapping modulo NUM_REQ. The first pending one wins. The sum is kept one
    // bit wider so the wrap also works when NUM_REQ is not a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (cand_sum >= (ID_W + 1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (ID_W + 1)'(NUM_REQ);
            end
            cand = cand_sum[ID_W-1:0];
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Data mux for the granted slice. The constant slice bounds keep the
    // selection free of variable part-selects.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == ID_W'(k)) begin
                grant_data = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Accept pulse is combinational. It is gated by rst_n so that a request
    // held during reset sees no ready.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_data      <= '0;
            rsp_error     <= 1'b0;
            sp_write      <= 1'b0;
            sp_write_data <= '0;
            sp_read       <= 1'b0;
        end else begin
            case (state)
                // Accept: capture the request and raise the write strobe for
                // the next cycle.
                IDLE: begin
                    if (grant_found) begin
                        state         <= WRITE;
                        ptr           <= next_ptr;
                        rsp_id        <= grant_idx;
                        rsp_data      <= '0;
                        rsp_error     <= 1'b0;
                        sp_write      <= 1'b1;
                        sp_write_data <= grant_data;
                    end
                end
                // Write: the strobe is visible for exactly this cycle.
                WRITE: begin
                    sp_write      <= 1'b0;
                    sp_write_data <= '0;
                    state         <= CHECK;
                end
                // Check: the processor reports the outcome of the write here.
                CHECK: begin
                    if (sp_error) begin
                        rsp_error <= 1'b1;
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        sp_read <= 1'b1;
                        state   <= READ;
                    end
                end
                // Read: the readback data is valid alongside the strobe.
                READ: begin
                    sp_read   <= 1'b0;
                    rsp_data  <= sp_read_data;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                // Respond: hold until the consumer takes the response.
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shape_processor_sequencer.sv
module tb_shape_processor_sequencer;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*32-1:0] req_data = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;
    logic                  rsp_error;
    logic                  sp_write;
    logic [31:0]           sp_write_data;
    logic                  sp_read;
    logic [31:0]           sp_read_data = '0;
    logic                  sp_error = 1'b0;
    logic                  busy;

    shape_processor_sequencer #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_error     (rsp_error),
        .sp_write      (sp_write),
        .sp_write_data (sp_write_data),
        .sp_read       (sp_read),
        .sp_read_data  (sp_read_data),
        .sp_error      (sp_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Transaction-level reference: one outstanding request, described by how
    // many cycles ago it was accepted and how the processor will answer it.
    bit          m_busy  = 1'b0;
    int          m_age   = 0;
    int          m_ptr   = 0;
    int          m_id    = 0;
    logic [31:0] m_wdata = '0;
    bit          m_err   = 1'b0;
    logic [31:0] m_rdata = '0;

    bit rand_mode = 1'b0;
    bit err_next  = 1'b0;
    int cyc       = 0;
    int g_id[$];
    int g_cyc[$];

    logic [3:0]  s_ready;
    logic        s_w, s_r, s_rv, s_re, s_busy;
    logic [31:0] s_wd, s_rd;
    logic [1:0]  s_id;

    typedef struct {
        logic [3:0]  v;
        logic        rr;
        logic        err;
        logic [3:0]  ready;
        logic        w;
        logic [31:0] wd;
        logic        r;
        logic        rv;
        logic [1:0]  id;
        logic [31:0] rd;
        logic        re;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic [3:0] v, logic rr, logic err, logic [3:0] ready,
                                logic w, logic [31:0] wd, logic r, logic rv,
                                logic [1:0] id, logic [31:0] rd, logic re);
        vec_t t;
        t.v = v; t.rr = rr; t.err = err; t.ready = ready; t.w = w; t.wd = wd;
        t.r = r; t.rv = rv; t.id = id; t.rd = rd; t.re = re;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // First pending requester searching upward from ptr, modulo NUM_REQ.
    function automatic int pick(logic [3:0] v, int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic bit in_resp();
        return m_busy && (m_age >= (m_err ? 3 : 4));
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
        chk({tag, "_rsp_data"}, rsp_data, 32'h0);
        chk({tag, "_rsp_error"}, 32'(rsp_error), 32'h0);
        chk({tag, "_sp_write"}, 32'(sp_write), 32'h0);
        chk({tag, "_sp_write_data"}, sp_write_data, 32'h0);
        chk({tag, "_sp_read"}, 32'(sp_read), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    // Called just after a rising edge. Pulls reset mid-cycle, checks that
    // every output drops at once, and releases it just after the next edge.
    task automatic apply_reset(input logic [3:0] v, input string tag);
        req_valid = v;
        #1 rst_n = 1'b0;
        #1 check_zero(tag);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_busy = 1'b0;
        m_age  = 0;
        m_ptr  = 0;
    endtask

    // One clock cycle: drive inputs, compare against the reference at the
    // falling edge, then advance the reference across the rising edge.
    task automatic cycle(input logic [3:0] v, input logic rr);
        logic [3:0] e_ready;
        int g;
        req_valid = v;
        rsp_ready = rr;
        if (rand_mode) begin
            for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = $urandom;
        end
        sp_error     = (m_busy && m_age == 2) ? m_err : 1'($urandom);
        sp_read_data = (m_busy && m_age == 3 && !m_err) ? m_rdata : $urandom;
        #4;
        s_ready = req_ready; s_w = sp_write; s_wd = sp_write_data; s_r = sp_read;
        s_rv = rsp_valid; s_id = rsp_id; s_rd = rsp_data; s_re = rsp_error; s_busy = busy;
        e_ready = '0;
        g = pick(v, m_ptr);
        if (!m_busy && g >= 0) e_ready[g] = 1'b1;
        chk("req_ready", 32'(s_ready), 32'(e_ready));
        chk("busy", 32'(s_busy), 32'(m_busy));
        chk("sp_write", 32'(s_w), 32'(m_busy && m_age == 1));
        if (m_busy && m_age == 1) chk("sp_write_data", s_wd, m_wdata);
        chk("sp_read", 32'(s_r), 32'(m_busy && !m_err && m_age == 3));
        chk("rsp_valid", 32'(s_rv), 32'(in_resp()));
        if (in_resp()) begin
            chk("rsp_id", 32'(s_id), 32'(m_id));
            chk("rsp_data", s_rd, m_err ? 32'h0 : m_rdata);
            chk("rsp_error", 32'(s_re), 32'(m_err));
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (s_ready[i]) begin
                g_id.push_back(i);
                g_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        cyc++;
        if (!m_busy) begin
            if (g >= 0) begin
                m_busy  = 1'b1;
                m_age   = 1;
                m_id    = g;
                m_wdata = req_data[32*g +: 32];
                m_ptr   = (g + 1) % NUM_REQ;
                m_err   = err_next;
                m_rdata = rand_mode ? 32'($urandom) : m_wdata;
            end
        end else if (in_resp() && rr) begin
            m_busy = 1'b0;
        end else begin
            m_age++;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp_data;
        logic [1:0]  bp_id;

        // v, rr, err, ready, w, wd, r, rv, id, rd, re
        tbl[0]  = mk(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[1]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 32'h12, 1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[2]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[3]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[4]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b1, 2'd0, 32'h12, 1'b0);
        tbl[5]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[6]  = mk(4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[7]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 32'h3F, 1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[8]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[9]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b1, 2'd2, 32'h0,  1'b1);
        tbl[10] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[11] = mk(4'b0101, 1'b1, 1'b0, 4'b0001, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[12] = mk(4'b0101, 1'b1, 1'b0, 4'b0000, 1'b1, 32'h12, 1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[13] = mk(4'b0101, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[14] = mk(4'b0101, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[15] = mk(4'b0101, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b1, 2'd0, 32'h12, 1'b0);
        tbl[16] = mk(4'b0101, 1'b1, 1'b0, 4'b0100, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[17] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 32'h3F, 1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[18] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[19] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[20] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b1, 2'd2, 32'h3F, 1'b0);
        tbl[21] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0, 32'h0,  1'b0);

        req_data = {32'h0000_0044, 32'h0000_003F, 32'h0000_0021, 32'h0000_0012};

        // Reset state, with every requester pending while reset is held.
        apply_reset(4'b1111, "reset");

        // Single request, error path, and wrap-and-skip from pointer 3.
        for (int i = 0; i < 22; i++) begin
            err_next = tbl[i].err;
            cycle(tbl[i].v, tbl[i].rr);
            chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].ready));
            chk($sformatf("tbl%0d_write", i), 32'(s_w), 32'(tbl[i].w));
            if (tbl[i].w) chk($sformatf("tbl%0d_wdata", i), s_wd, tbl[i].wd);
            chk($sformatf("tbl%0d_read", i), 32'(s_r), 32'(tbl[i].r));
            chk($sformatf("tbl%0d_rvalid", i), 32'(s_rv), 32'(tbl[i].rv));
            if (tbl[i].rv) begin
                chk($sformatf("tbl%0d_rid", i), 32'(s_id), 32'(tbl[i].id));
                chk($sformatf("tbl%0d_rdata", i), s_rd, tbl[i].rd);
                chk($sformatf("tbl%0d_rerr", i), 32'(s_re), 32'(tbl[i].re));
            end
        end

        // Round-robin with all requesters pending, starting from pointer 0.
        apply_reset(4'b0000, "reset_idle");
        err_next = 1'b0;
        g_id.delete();
        g_cyc.delete();
        for (int i = 0; i < 25; i++) cycle(4'b1111, 1'b1);
        chk("rr_count", 32'(g_id.size()), 32'd5);
        for (int i = 0; i < g_id.size() && i < 5; i++) begin
            chk($sformatf("rr_order%0d", i), 32'(g_id[i]), 32'(i % NUM_REQ));
            if (i > 0) chk($sformatf("rr_spacing%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd5);
        end
        for (int i = 0; i < 6; i++) cycle(4'b0000, 1'b1);

        // Backpressure: response held for six cycles with rsp_ready low.
        cycle(4'b0001, 1'b1);
        bp_data = '0;
        bp_id   = '0;
        for (int i = 0; i < 9; i++) begin
            cycle(4'b0011, 1'b0);
            if (i == 3) begin
                bp_data = s_rd;
                bp_id   = s_id;
            end
            if (i > 3) begin
                chk("bp_valid_held", 32'(s_rv), 32'd1);
                chk("bp_data_stable", s_rd, bp_data);
                chk("bp_id_stable", 32'(s_id), 32'(bp_id));
                chk("bp_no_ready", 32'(s_ready), 32'h0);
                chk("bp_no_write", 32'(s_w), 32'h0);
            end
        end
        cycle(4'b0011, 1'b1);
        cycle(4'b0011, 1'b1);
        chk("bp_resume", 32'(s_ready), 32'b0010);

        // Reset while the sequencer is in the read step.
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        chk("pre_reset_age", 32'(m_age), 32'd3);
        apply_reset(4'b0010, "reset_mid");
        cycle(4'b0010, 1'b1);
        chk("reset_regrant", 32'(s_ready), 32'b0010);
        for (int i = 0; i < 5; i++) cycle(4'b0000, 1'b1);

        // Randomized traffic against the reference model.
        rand_mode = 1'b1;
        for (int i = 0; i < 800; i++) begin
            err_next = ($urandom_range(0, 3) == 0);
            cycle(4'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
